// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature step generator.
package quad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Direction latched at detent start; CW counts as +1, CCW as -1.
  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_t;

  localparam int unsigned STEPS_PER_DETENT = 4;
  localparam int unsigned PHASE_W          = 2;
  localparam int unsigned TIMER_W          = 16;

  // {A,B} value emitted on each advance, indexed by phase index.
  localparam logic [1:0] CW_SEQ  [STEPS_PER_DETENT] = '{2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] CCW_SEQ [STEPS_PER_DETENT] = '{2'b01, 2'b11, 2'b10, 2'b00};

endpackage

// File: rtl/step_prescaler.sv
// Paces A/B transitions: one tick every STEP_DIV cycles while running.
module step_prescaler
  import quad_pkg::*;
#(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic tick_c
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(STEP_DIV - 1);

  logic [TIMER_W-1:0] timer;

  assign tick_c = run && (timer == '0);

  // Load on detent start, count down while running, reload on each tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (load) begin
      timer <= RELOAD;
    end else if (run) begin
      timer <= tick_c ? RELOAD : timer - TIMER_W'(1);
    end
  end

endmodule

// File: rtl/quadrature_step_gen.sv
// Emits one Gray-coded A/B detent per pending request, with a saturating
// signed pending-detent counter.
module quadrature_step_gen
  import quad_pkg::*;
#(
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned PEND_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_up,
  input  logic              step_down,
  output logic              A,
  output logic              B,
  output logic              busy,
  output logic              detent_done,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  localparam int unsigned SUM_W = PEND_W + 2;
  localparam logic signed [SUM_W-1:0] P_MAX = SUM_W'(2 ** (PEND_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] P_MIN = ~P_MAX;

  state_t               state, state_next;
  dir_t                 dir, dir_next;
  logic [PHASE_W-1:0]   phase, phase_next;
  logic [1:0]           ab_next;
  logic                 done_next;
  logic                 load_c;
  logic                 tick_c;
  logic signed [2:0]    delta_c;
  logic signed [SUM_W-1:0] sum_c;
  logic [PEND_W-1:0]    pending_next;
  logic                 ovf_next;

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .run    (state == RUN),
    .tick_c (tick_c)
  );

  // Next state, direction latch, phase advance and A/B stepping.
  always_comb begin
    state_next = state;
    dir_next   = dir;
    phase_next = phase;
    ab_next    = {A, B};
    done_next  = 1'b0;
    load_c     = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          state_next = RUN;
          dir_next   = pending[PEND_W-1] ? DIR_CCW : DIR_CW;
          phase_next = '0;
          load_c     = 1'b1;
        end
      end
      RUN: begin
        if (tick_c) begin
          ab_next    = (dir == DIR_CW) ? CW_SEQ[phase] : CCW_SEQ[phase];
          phase_next = phase + PHASE_W'(1);
          if (phase == PHASE_W'(STEPS_PER_DETENT - 1)) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Net pending delta (request plus completion), then clamp to PEND_W signed range.
  always_comb begin
    delta_c = 3'sd0;
    if (step_up && !step_down) begin
      delta_c = 3'sd1;
    end else if (step_down && !step_up) begin
      delta_c = -3'sd1;
    end
    if (done_next) begin
      delta_c = (dir == DIR_CW) ? delta_c - 3'sd1 : delta_c + 3'sd1;
    end
    sum_c = $signed({{2{pending[PEND_W-1]}}, pending})
          + $signed({{(SUM_W-3){delta_c[2]}}, delta_c});
    ovf_next     = 1'b0;
    pending_next = sum_c[PEND_W-1:0];
    if (sum_c > P_MAX) begin
      pending_next = P_MAX[PEND_W-1:0];
      ovf_next     = 1'b1;
    end else if (sum_c < P_MIN) begin
      pending_next = P_MIN[PEND_W-1:0];
      ovf_next     = 1'b1;
    end
  end

  // State and output registers; reset aborts any detent in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dir         <= DIR_CW;
      phase       <= '0;
      A           <= 1'b0;
      B           <= 1'b0;
      busy        <= 1'b0;
      detent_done <= 1'b0;
      pending     <= '0;
      ovf         <= 1'b0;
    end else begin
      state       <= state_next;
      dir         <= dir_next;
      phase       <= phase_next;
      {A, B}      <= ab_next;
      busy        <= (state_next == RUN);
      detent_done <= done_next;
      pending     <= pending_next;
      ovf         <= ovf_next;
    end
  end

endmodule

// File: tb/tb_quadrature_step_gen.sv
// Directed bench for quadrature_step_gen: vector table plus corner sequences.
module tb_quadrature_step_gen;

  logic clk;
  logic rst;

  // Main instance: STEP_DIV=4, PEND_W=8
  logic       up0, dn0, a0, b0, busy0, done0, ovf0;
  logic [7:0] pend0;
  // Saturation instance: STEP_DIV=4, PEND_W=4
  logic       up4, dn4, a4, b4, busy4, done4, ovf4;
  logic [3:0] pend4;
  // Fast instance: STEP_DIV=1, PEND_W=8
  logic       up1, dn1, a1, b1, busy1, done1, ovf1;
  logic [7:0] pend1;

  int checks = 0;
  int errors = 0;
  int trans_cnt = 0;
  int done_cnt = 0;
  logic [1:0] ab_prev = 2'b00;

  quadrature_step_gen #(.STEP_DIV(4), .PEND_W(8)) dut (
    .clk(clk), .rst(rst), .step_up(up0), .step_down(dn0),
    .A(a0), .B(b0), .busy(busy0), .detent_done(done0), .pending(pend0), .ovf(ovf0)
  );

  quadrature_step_gen #(.STEP_DIV(4), .PEND_W(4)) dut4 (
    .clk(clk), .rst(rst), .step_up(up4), .step_down(dn4),
    .A(a4), .B(b4), .busy(busy4), .detent_done(done4), .pending(pend4), .ovf(ovf4)
  );

  quadrature_step_gen #(.STEP_DIV(1), .PEND_W(8)) dut1 (
    .clk(clk), .rst(rst), .step_up(up1), .step_down(dn1),
    .A(a1), .B(b1), .busy(busy1), .detent_done(done1), .pending(pend1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count A/B transitions and detent completions of the main instance.
  always @(negedge clk) begin
    if ({a0, b0} != ab_prev) trans_cnt++;
    ab_prev = {a0, b0};
    if (done0) done_cnt++;
  end

  typedef struct {
    logic       up;
    logic       dn;
    int         ncyc;
    logic [1:0] ab;
    logic       busy;
    logic       done;
    logic [7:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic up, input logic dn, input int ncyc,
                              input logic [1:0] ab, input logic busy, input logic done,
                              input logic [7:0] pend);
    vec_t v;
    v.up = up; v.dn = dn; v.ncyc = ncyc; v.ab = ab;
    v.busy = busy; v.done = done; v.pend = pend; v.ovf = 1'b0;
    vecs.push_back(v);
  endfunction

  initial begin
    string nm;
    // Single CW detent: RUN one cycle after pending, edges every 4 cycles.
    add(1,0,1, 2'b00,0,0,8'h01);
    add(0,0,1, 2'b00,1,0,8'h01);
    add(0,0,3, 2'b00,1,0,8'h01);
    add(0,0,1, 2'b10,1,0,8'h01);
    add(0,0,4, 2'b11,1,0,8'h01);
    add(0,0,4, 2'b01,1,0,8'h01);
    add(0,0,4, 2'b00,0,1,8'h00);
    add(0,0,1, 2'b00,0,0,8'h00);
    // Single CCW detent
    add(0,1,1, 2'b00,0,0,8'hFF);
    add(0,0,1, 2'b00,1,0,8'hFF);
    add(0,0,3, 2'b00,1,0,8'hFF);
    add(0,0,1, 2'b01,1,0,8'hFF);
    add(0,0,4, 2'b11,1,0,8'hFF);
    add(0,0,4, 2'b10,1,0,8'hFF);
    add(0,0,4, 2'b00,0,1,8'h00);
    add(0,0,1, 2'b00,0,0,8'h00);
    // Simultaneous up/down cancels
    add(1,1,1, 2'b00,0,0,8'h00);
    add(0,0,5, 2'b00,0,0,8'h00);
    // Three back-to-back CW detents with one idle cycle between
    add(1,0,1, 2'b00,0,0,8'h01);
    add(1,0,1, 2'b00,1,0,8'h02);
    add(1,0,1, 2'b00,1,0,8'h03);
    add(0,0,15,2'b00,0,1,8'h02);
    add(0,0,1, 2'b00,1,0,8'h02);
    add(0,0,16,2'b00,0,1,8'h01);
    add(0,0,1, 2'b00,1,0,8'h01);
    add(0,0,16,2'b00,0,1,8'h00);
    add(0,0,1, 2'b00,0,0,8'h00);
    // CW detent with mid-detent requests, followed by one CCW detent
    add(1,0,1, 2'b00,0,0,8'h01);
    add(0,0,5, 2'b10,1,0,8'h01);
    add(0,0,3, 2'b10,1,0,8'h01);
    add(1,0,1, 2'b11,1,0,8'h02);
    add(0,1,1, 2'b11,1,0,8'h01);
    add(0,1,1, 2'b11,1,0,8'h00);
    add(0,0,1, 2'b11,1,0,8'h00);
    add(0,0,1, 2'b01,1,0,8'h00);
    add(0,0,4, 2'b00,0,1,8'hFF);
    add(0,0,1, 2'b00,1,0,8'hFF);
    add(0,0,4, 2'b01,1,0,8'hFF);
    add(0,0,4, 2'b11,1,0,8'hFF);
    add(0,0,4, 2'b10,1,0,8'hFF);
    add(0,0,4, 2'b00,0,1,8'h00);
    add(0,0,2, 2'b00,0,0,8'h00);

    rst = 1'b0;
    up0 = 0; dn0 = 0; up4 = 0; dn4 = 0; up1 = 0; dn1 = 0;
    repeat (3) tick();
    chk("reset_ab",   {30'd0, a0, b0}, 32'd0);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_done", {31'd0, done0}, 32'd0);
    chk("reset_pend", {24'd0, pend0}, 32'd0);
    chk("reset_ovf",  {31'd0, ovf0}, 32'd0);
    rst = 1'b1;
    tick();
    chk("post_reset_busy", {31'd0, busy0}, 32'd0);

    // Table-driven vectors on the main instance
    for (int i = 0; i < vecs.size(); i++) begin
      up0 = vecs[i].up;
      dn0 = vecs[i].dn;
      tick();
      up0 = 0;
      dn0 = 0;
      repeat (vecs[i].ncyc - 1) tick();
      nm = $sformatf("vec%0d", i);
      chk({nm, "_ab"},   {30'd0, a0, b0},   {30'd0, vecs[i].ab});
      chk({nm, "_busy"}, {31'd0, busy0},    {31'd0, vecs[i].busy});
      chk({nm, "_done"}, {31'd0, done0},    {31'd0, vecs[i].done});
      chk({nm, "_pend"}, {24'd0, pend0},    {24'd0, vecs[i].pend});
      chk({nm, "_ovf"},  {31'd0, ovf0},     {31'd0, vecs[i].ovf});
    end
    chk("total_transitions", trans_cnt, 28);
    chk("total_detents", done_cnt, 7);

    // STEP_DIV=1: one transition per cycle in RUN
    begin
      logic [1:0] seq [4];
      seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
      up1 = 1;
      tick();
      up1 = 0;
      chk("div1_pend", {24'd0, pend1}, 32'd1);
      chk("div1_busy0", {31'd0, busy1}, 32'd0);
      tick();
      chk("div1_busy1", {31'd0, busy1}, 32'd1);
      chk("div1_ab_start", {30'd0, a1, b1}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        tick();
        chk($sformatf("div1_ab%0d", k), {30'd0, a1, b1}, {30'd0, seq[k]});
        chk($sformatf("div1_done%0d", k), {31'd0, done1}, (k == 3) ? 32'd1 : 32'd0);
      end
      chk("div1_pend_end", {24'd0, pend1}, 32'd0);
      chk("div1_busy_end", {31'd0, busy1}, 32'd0);
      tick();
      chk("div1_done_clear", {31'd0, done1}, 32'd0);
    end

    // PEND_W=4 saturation, then reset mid-detent
    for (int k = 0; k < 9; k++) begin
      up4 = 1;
      tick();
      chk($sformatf("sat_pend%0d", k), {28'd0, pend4}, (k < 7) ? k + 1 : 7);
      chk($sformatf("sat_ovf%0d", k), {31'd0, ovf4}, (k >= 7) ? 32'd1 : 32'd0);
    end
    up4 = 0;
    tick();
    chk("sat_ovf_clear", {31'd0, ovf4}, 32'd0);
    chk("sat_pend_hold", {28'd0, pend4}, 32'd7);
    chk("sat_ab_mid", {30'd0, a4, b4}, 32'h3);
    chk("sat_busy_mid", {31'd0, busy4}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ab", {30'd0, a4, b4}, 32'd0);
    chk("arst_pend", {28'd0, pend4}, 32'd0);
    chk("arst_busy", {31'd0, busy4}, 32'd0);
    chk("arst_done", {31'd0, done4}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("arst_hold_done%0d", k), {31'd0, done4}, 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post_arst_busy%0d", k), {31'd0, busy4}, 32'd0);
      chk($sformatf("post_arst_done%0d", k), {31'd0, done4}, 32'd0);
    end
    chk("post_arst_pend", {28'd0, pend4}, 32'd0);
    chk("post_arst_ab", {30'd0, a4, b4}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
